uart_event_link: RTL and testbench
==================================

# uart_event_link

Parametrised event-messaging layer between game logic and the byte-level UART in the multiplayer link. It encodes up to `N_EVENTS` local event flags, such as game over, ready and hit, into one-byte codes. Pending events are queued and sent round-robin while respecting UART back-pressure. In the other direction it decodes received bytes into per-channel pulses and sticky flags. Compared with the fixed three-message scheme it replaces, it adds coalescing counters, unknown-byte accounting, a minimum inter-byte gap and per-channel clear.

## Interface
Parameters:
- `N_EVENTS`, 4: number of event channels. Legal range 1..16.
- `CODE_BASE`, 8'h41: code of channel 0. Channel i sends `CODE_BASE+i`. `CODE_BASE+N_EVENTS` must be ≤ 256.
- `GAP_CYCLES`, 16: minimum number of clk cycles from one `wr_uart` pulse to the next. Legal range ≥ 1.
- `CNT_W`, 8: width of the diagnostic counters.

Ports:
- `clk`, in, 1: system clock. One clock; all logic is on its rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `link_en`, in, 1: link enable, driven by the multiplayer selection.
- `ev_in`, in, N_EVENTS: local event levels. A rising edge requests a send.
- `ev_clr`, in, N_EVENTS: per-channel clear for `ev_rx_level`.
- `tx_full`, in, 1: UART TX FIFO full.
- `wr_uart`, out, 1: one-cycle write strobe to the UART.
- `w_data`, out, 8: byte to send. Valid while `wr_uart`=1.
- `rx_done_tick`, in, 1: UART byte-received strobe.
- `r_data`, in, 8: received byte. Valid with `rx_done_tick`.
- `ev_rx_pulse`, out, N_EVENTS: one-cycle pulse per decoded remote event.
- `ev_rx_level`, out, N_EVENTS: sticky remote-event flags.
- `drop_cnt`, out, CNT_W: count of coalesced (lost) local events. Saturating.
- `unk_cnt`, out, CNT_W: count of received bytes outside the code range. Saturating.

## Operation
- **Reset:** every output is 0. Internal state also resets: `pending`=0, `ev_prev`=0, round-robin pointer `rr`=N_EVENTS-1, gap counter=0.
- **Edge detection:**
  - `ev_prev` registers `ev_in` every cycle, regardless of `link_en`, so enabling the link never creates a false edge.
  - `rise = ev_in & ~ev_prev`.
- **Pending set:** with `link_en`=1, `rise[i]` sets `pending[i]`.
- **Coalescing:** if `pending[i]` is already 1 and is not being granted in the same cycle, the new edge is coalesced and `drop_cnt` increments by 1. It saturates at 2^CNT_W−1.
- **Send condition:** a grant is issued in a cycle when all of the following hold:
  - `link_en`=1
  - `tx_full`=0
  - gap counter = 0
  - `pending` ≠ 0
- **Grant selection:** the granted channel is the first set bit searched upward from `rr+1`, wrapping modulo N_EVENTS.
- **Effects of a grant (next edge):**
  - `wr_uart`←1 and `w_data`←`CODE_BASE+idx`.
  - `pending[idx]` is cleared.
  - `rr`←idx.
  - The gap counter loads `GAP_CYCLES-1`.
- **Grant and rise on the same channel:** the pending bit stays set. This is not counted as a drop.
- **Outside a grant:** `wr_uart`←0. `w_data` holds its last value. The gap counter decrements toward 0.
- **`link_en`=0:**
  - `pending` clears and no writes occur.
  - Received bytes are ignored: no pulse, no level change, no `unk_cnt` increment.
  - `ev_rx_level` holds its value.
  - Counters hold their values.
- **RX decode:** with `link_en`=1, on `rx_done_tick`=1:
  - If `r_data - CODE_BASE` < N_EVENTS (8-bit unsigned compare, no wrap), then at the next edge `ev_rx_pulse[idx]`←1 for exactly one cycle and `ev_rx_level[idx]`←1.
  - Otherwise `unk_cnt` increments, saturating.
- **Clearing levels:** `ev_clr[i]` clears `ev_rx_level[i]` at the next edge. If set and clear occur in the same cycle, set wins.
- **Independence:** the TX path and RX path are independent. Simultaneous activity on both has no interaction.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- **TX latency:**
  - `ev_in` is first sampled high at edge k, which sets `pending` at edge k.
  - Earliest `wr_uart`=1 is the cycle after edge k+1.
- **Back-pressure:** while `tx_full`=1 no strobe is issued and pending bits are held. A strobe is never issued in a cycle where `tx_full` was sampled 1.
- **Strobe spacing:** consecutive `wr_uart` pulses are at least `GAP_CYCLES` cycles apart. With GAP_CYCLES=1 they may occur back-to-back.
- **RX latency:** `rx_done_tick` sampled at edge k produces `ev_rx_pulse` high during the cycle after edge k. `ev_rx_level` is high from edge k.
- **Asynchronous reset mid-transfer:** `wr_uart` drops immediately. Queued events are discarded and are not resent after release.

## Test plan
- **Single event:** N=4, CODE_BASE=8'h41, GAP=16. Pulse `ev_in[2]` -> exactly one `wr_uart` strobe with `w_data`=8'h43, two cycles after the edge.
- **Round-robin:** rise on `ev_in[3:0]`=4'b1011 in one cycle -> sends 8'h41, 8'h42, 8'h44, in that order, spaced by exactly 16 cycles. Then `pending`=0 and `drop_cnt`=0.
- **Back-pressure and coalescing:** hold `tx_full`=1 and toggle `ev_in[0]` three times -> no strobes and `drop_cnt`=2. Release `tx_full` -> exactly one 8'h41.
- **RX decode and clear:**
  - `rx_done_tick` with `r_data`=8'h44 -> `ev_rx_pulse`=4'b1000 for one cycle and `ev_rx_level[3]`=1.
  - `ev_clr[3]` at the same time as a new 8'h44 -> level stays 1.
  - `ev_clr[3]` alone -> level goes to 0.
- **Unknown bytes and saturation:** 300 bytes of 8'h40 (CNT_W=8) -> `unk_cnt`=255, no pulses. A byte of 8'h45 -> counted as unknown.
- **Enable and reset:**
  - `link_en`=0 with edges and RX bytes present -> no strobes and no pulses. Raising `link_en` while `ev_in` is held high -> no send.
  - Assert `rst` with events pending -> all outputs 0 immediately, and nothing is sent after release.

Source files
------------

// File: rtl/uart_event_link_if.sv
// Byte-level UART handshake between the event link and the UART core.
// The master side is the event link: it writes bytes and consumes received ones.
interface uart_event_link_if;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       rx_done_tick;
    logic [7:0] r_data;

    modport master (
        input  tx_full,
        input  rx_done_tick,
        input  r_data,
        output wr_uart,
        output w_data
    );

    modport slave (
        output tx_full,
        output rx_done_tick,
        output r_data,
        input  wr_uart,
        input  w_data
    );
endinterface

// File: rtl/uart_event_link.sv
// Event-messaging layer for the multiplayer link.
// TX: rising edges on local event flags queue one-byte codes, sent round-robin
// with a minimum inter-byte gap and UART back-pressure. Repeat edges on an
// already-queued channel are coalesced and counted.
// RX: received codes become per-channel pulses and sticky levels; bytes outside
// the code range are counted as unknown.
module uart_event_link #(
    parameter int         N_EVENTS   = 4,
    parameter logic [7:0] CODE_BASE  = 8'h41,
    parameter int         GAP_CYCLES = 16,
    parameter int         CNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                link_en,
    input  logic [N_EVENTS-1:0] ev_in,
    input  logic [N_EVENTS-1:0] ev_clr,
    uart_event_link_if.master   uart,
    output logic [N_EVENTS-1:0] ev_rx_pulse,
    output logic [N_EVENTS-1:0] ev_rx_level,
    output logic [CNT_W-1:0]    drop_cnt,
    output logic [CNT_W-1:0]    unk_cnt
);

    localparam int                RR_W     = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1;
    localparam int                GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int                SUM_W    = CNT_W + 5;
    localparam logic [RR_W-1:0]   RR_LAST  = RR_W'(N_EVENTS - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [N_EVENTS-1:0]   ev_prev;
    logic [N_EVENTS-1:0]   pending;
    logic [N_EVENTS-1:0]   pending_next;
    logic [N_EVENTS-1:0]   rise;
    logic [RR_W-1:0]       rr;
    logic [RR_W-1:0]       rr_start;
    logic [RR_W-1:0]       grant_idx;
    logic [N_EVENTS-1:0]   grant_oh;
    logic [2*N_EVENTS-1:0] pend_dbl;
    logic [N_EVENTS-1:0]   pend_rot;
    logic                  found;
    logic                  grant;
    logic [GAP_W-1:0]      gap_cnt;
    logic [N_EVENTS-1:0]   drop_vec;
    logic [4:0]            drop_add;
    logic [SUM_W-1:0]      drop_sum;
    logic [7:0]            rx_off;
    logic                  rx_take;
    logic                  rx_known;
    logic [N_EVENTS-1:0]   rx_set;

    assign rise = ev_in & ~ev_prev;

    // Round-robin arbiter: rotate pending so the search starts just after the last grant.
    always_comb begin
        rr_start  = (rr == RR_LAST) ? '0 : rr + 1'b1;
        pend_dbl  = {pending, pending} >> rr_start;
        pend_rot  = pend_dbl[N_EVENTS-1:0];
        found     = 1'b0;
        grant_idx = rr;
        for (int j = 0; j < N_EVENTS; j++) begin
            if (!found && pend_rot[j]) begin
                found     = 1'b1;
                grant_idx = (int'(rr_start) + j >= N_EVENTS) ?
                            RR_W'(int'(rr_start) + j - N_EVENTS) :
                            RR_W'(int'(rr_start) + j);
            end
        end
        grant    = link_en && !uart.tx_full && (gap_cnt == '0) && found;
        grant_oh = grant ? (N_EVENTS'(1) << grant_idx) : '0;
    end

    // Next pending set and the number of edges lost to coalescing this cycle.
    always_comb begin
        pending_next = link_en ? ((pending & ~grant_oh) | rise) : '0;
        drop_vec     = link_en ? (rise & pending & ~grant_oh) : '0;
        drop_add     = '0;
        for (int j = 0; j < N_EVENTS; j++) begin
            drop_add = drop_add + 5'(drop_vec[j]);
        end
        drop_sum = SUM_W'(drop_cnt) + SUM_W'(drop_add);
    end

    // Decode a received byte into a channel index or an unknown-byte event.
    always_comb begin
        rx_off   = uart.r_data - CODE_BASE;
        rx_take  = link_en && uart.rx_done_tick;
        rx_known = rx_off < 8'(N_EVENTS);
        rx_set   = (rx_take && rx_known) ? (N_EVENTS'(1) << rx_off) : '0;
    end

    // TX state: edge history, queue, arbiter pointer, gap timer, strobe and drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_prev      <= '0;
            pending      <= '0;
            rr           <= RR_LAST;
            gap_cnt      <= '0;
            uart.wr_uart <= 1'b0;
            uart.w_data  <= '0;
            drop_cnt     <= '0;
        end else begin
            ev_prev      <= ev_in;
            pending      <= pending_next;
            uart.wr_uart <= grant;
            if (grant) begin
                rr          <= grant_idx;
                gap_cnt     <= GAP_LOAD;
                uart.w_data <= CODE_BASE + 8'(grant_idx);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
            if (drop_sum > SUM_W'(CNT_MAX)) begin
                drop_cnt <= CNT_MAX;
            end else begin
                drop_cnt <= drop_sum[CNT_W-1:0];
            end
        end
    end

    // RX state: one-cycle pulses, sticky levels (set beats clear), unknown-byte counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_rx_pulse <= '0;
            ev_rx_level <= '0;
            unk_cnt     <= '0;
        end else begin
            ev_rx_pulse <= rx_set;
            if (link_en) begin
                ev_rx_level <= (ev_rx_level & ~ev_clr) | rx_set;
            end
            if (rx_take && !rx_known && unk_cnt != CNT_MAX) begin
                unk_cnt <= unk_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_event_link.sv
// Self-checking bench for uart_event_link: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// behavioural model of the event link.
module tb_uart_event_link;

    localparam int         N    = 4;
    localparam logic [7:0] BASE = 8'h41;
    localparam int         GAP  = 16;
    localparam int         CW   = 8;
    localparam int         CMAX = 255;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          link_en = 1'b0;
    logic [N-1:0]  ev_in   = '0;
    logic [N-1:0]  ev_clr  = '0;
    logic [N-1:0]  ev_rx_pulse;
    logic [N-1:0]  ev_rx_level;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] unk_cnt;

    uart_event_link_if uart ();

    uart_event_link #(
        .N_EVENTS  (N),
        .CODE_BASE (BASE),
        .GAP_CYCLES(GAP),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .link_en    (link_en),
        .ev_in      (ev_in),
        .ev_clr     (ev_clr),
        .uart       (uart.master),
        .ev_rx_pulse(ev_rx_pulse),
        .ev_rx_level(ev_rx_level),
        .drop_cnt   (drop_cnt),
        .unk_cnt    (unk_cnt)
    );

    // 10-unit clock period
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cycle_cnt   = 0;

    // Behavioural model state, initialised to the reset state
    bit         m_pend[N];
    bit         m_prev[N];
    int         m_rr    = N - 1;
    int         m_gap   = 0;
    int         m_drop  = 0;
    int         m_unk   = 0;
    logic [N-1:0] m_pulse = '0;
    logic [N-1:0] m_level = '0;
    logic       m_wr    = 1'b0;
    logic [7:0] m_wdata = '0;

    // Observed write strobes: cycle number and byte
    int         s_cyc[$];
    logic [7:0] s_data[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle_cnt);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] ev, input logic [N-1:0] clr, input logic txf,
                                 input logic rxd, input logic [7:0] rdata);
        @(posedge clk);
        #2;
        ev_in             = ev;
        ev_clr            = clr;
        uart.tx_full      = txf;
        uart.rx_done_tick = rxd;
        uart.r_data       = rdata;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(ev_in, '0, uart.tx_full, 1'b0, 8'h00);
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_prev[i] = 1'b0;
        end
        m_rr = N - 1; m_gap = 0; m_drop = 0; m_unk = 0;
        m_pulse = '0; m_level = '0; m_wr = 1'b0; m_wdata = '0;
    endtask

    task automatic modelStep();
        bit rise[N];
        bit any;
        bit grant;
        int idx;
        int off;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            rise[i] = ev_in[i] && !m_prev[i];
            any     = any || m_pend[i];
        end
        grant = link_en && !uart.tx_full && (m_gap == 0) && any;
        idx   = -1;
        if (grant) begin
            for (int k = 1; k <= N; k++) begin
                if (idx < 0 && m_pend[(m_rr + k) % N]) idx = (m_rr + k) % N;
            end
            m_wdata = BASE + 8'(idx);
        end
        m_wr = grant;
        for (int i = 0; i < N; i++) begin
            if (link_en && rise[i] && m_pend[i] && !(grant && idx == i) && m_drop < CMAX) m_drop++;
        end
        for (int i = 0; i < N; i++) begin
            m_pend[i] = link_en && ((m_pend[i] && !(grant && idx == i)) || rise[i]);
            m_prev[i] = ev_in[i];
        end
        if (grant) m_rr = idx;
        m_gap   = grant ? GAP - 1 : (m_gap > 0 ? m_gap - 1 : 0);
        m_pulse = '0;
        if (link_en && uart.rx_done_tick) begin
            off = (int'(uart.r_data) - int'(BASE) + 256) % 256;
            if (off < N) begin
                m_pulse[off] = 1'b1;
                m_level[off] = 1'b1;
            end else if (m_unk < CMAX) begin
                m_unk++;
            end
        end
        if (link_en) m_level = (m_level & ~ev_clr) | m_pulse;
    endtask

    // Advance the model on every clock edge; reset it asynchronously like the DUT
    always @(posedge clk or posedge rst) begin
        if (rst) modelReset();
        else     modelStep();
    end

    // Cycle counter used for latency and spacing measurements
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Compare every DUT output against the model mid-cycle and log strobes
    always @(negedge clk) begin
        checkOutput("wr_uart", 32'(uart.wr_uart), 32'(m_wr));
        checkOutput("w_data", 32'(uart.w_data), 32'(m_wdata));
        checkOutput("ev_rx_pulse", 32'(ev_rx_pulse), 32'(m_pulse));
        checkOutput("ev_rx_level", 32'(ev_rx_level), 32'(m_level));
        checkOutput("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        checkOutput("unk_cnt", 32'(unk_cnt), 32'(m_unk));
        if (uart.wr_uart === 1'b1) begin
            s_cyc.push_back(cycle_cnt);
            s_data.push_back(uart.w_data);
        end
    end

    // Directed scenarios, then randomized traffic
    initial begin
        int base_n;
        int t0;
        logic [N-1:0] ev;
        logic [N-1:0] clr;
        logic [7:0]   rd;

        uart.tx_full      = 1'b0;
        uart.rx_done_tick = 1'b0;
        uart.r_data       = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        rst     = 1'b0;
        link_en = 1'b1;
        idle(2);

        // Round-robin from reset: 4'b1011 sends 41, 42, 44 spaced 16 cycles
        base_n = s_cyc.size();
        applyStimulus(4'b1011, '0, 1'b0, 1'b0, 8'h00);
        applyStimulus(4'b0000, '0, 1'b0, 1'b0, 8'h00);
        idle(60);
        checkOutput("rr_count", 32'(s_cyc.size() - base_n), 32'd3);
        if (s_cyc.size() - base_n == 3) begin
            checkOutput("rr_byte0", 32'(s_data[base_n]), 32'h41);
            checkOutput("rr_byte1", 32'(s_data[base_n + 1]), 32'h42);
            checkOutput("rr_byte2", 32'(s_data[base_n + 2]), 32'h44);
            checkOutput("rr_space1", 32'(s_cyc[base_n + 1] - s_cyc[base_n]), 32'd16);
            checkOutput("rr_space2", 32'(s_cyc[base_n + 2] - s_cyc[base_n + 1]), 32'd16);
        end
        checkOutput("rr_drop", 32'(drop_cnt), 32'd0);

        // Single event on channel 2: one strobe of 43, two cycles after driving
        base_n = s_cyc.size();
        applyStimulus(4'b0100, '0, 1'b0, 1'b0, 8'h00);
        t0 = cycle_cnt;
        applyStimulus(4'b0000, '0, 1'b0, 1'b0, 8'h00);
        idle(30);
        checkOutput("single_count", 32'(s_cyc.size() - base_n), 32'd1);
        if (s_cyc.size() - base_n == 1) begin
            checkOutput("single_byte", 32'(s_data[base_n]), 32'h43);
            checkOutput("single_latency", 32'(s_cyc[base_n] - t0), 32'd2);
        end

        // Back-pressure: three edges on channel 0 while full, two coalesced
        base_n = s_cyc.size();
        applyStimulus(4'b0000, '0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0001, '0, 1'b1, 1'b0, 8'h00);
            applyStimulus(4'b0000, '0, 1'b1, 1'b0, 8'h00);
        end
        idle(10);
        checkOutput("bp_no_strobe", 32'(s_cyc.size() - base_n), 32'd0);
        checkOutput("bp_drop", 32'(drop_cnt), 32'd2);
        applyStimulus(4'b0000, '0, 1'b0, 1'b0, 8'h00);
        idle(30);
        checkOutput("bp_release_count", 32'(s_cyc.size() - base_n), 32'd1);
        if (s_cyc.size() - base_n == 1) checkOutput("bp_release_byte", 32'(s_data[base_n]), 32'h41);

        // RX decode of 44, then clear racing a set, then clear alone
        applyStimulus('0, '0, 1'b0, 1'b1, 8'h44);
        applyStimulus('0, '0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("rx_pulse", 32'(ev_rx_pulse), 32'b1000);
        checkOutput("rx_level3", 32'(ev_rx_level[3]), 32'd1);
        applyStimulus('0, '0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("rx_pulse_once", 32'(ev_rx_pulse), 32'd0);
        applyStimulus('0, 4'b1000, 1'b0, 1'b1, 8'h44);
        applyStimulus('0, '0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("rx_set_wins", 32'(ev_rx_level[3]), 32'd1);
        applyStimulus('0, 4'b1000, 1'b0, 1'b0, 8'h00);
        applyStimulus('0, '0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("rx_clear", 32'(ev_rx_level[3]), 32'd0);

        // Unknown bytes: 45 is just past the range, then 300 of 40 saturate
        applyStimulus('0, '0, 1'b0, 1'b1, 8'h45);
        applyStimulus('0, '0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("unk_45", 32'(unk_cnt), 32'd1);
        checkOutput("unk_45_pulse", 32'(ev_rx_pulse), 32'd0);
        for (int i = 0; i < 300; i++) applyStimulus('0, '0, 1'b0, 1'b1, 8'h40);
        applyStimulus('0, '0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("unk_saturate", 32'(unk_cnt), 32'd255);

        // Link disabled: edges, bytes and clears have no effect; enabling with ev held sends nothing
        applyStimulus('0, '0, 1'b0, 1'b1, 8'h42);
        applyStimulus('0, '0, 1'b0, 1'b0, 8'h00);
        idle(20);
        base_n  = s_cyc.size();
        link_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0110, 4'b0010, 1'b0, 1'b1, 8'h42);
            applyStimulus(4'b0000, 4'b0010, 1'b0, 1'b1, 8'h41);
        end
        applyStimulus(4'b0010, '0, 1'b0, 1'b0, 8'h00);
        idle(3);
        link_en = 1'b1;
        idle(40);
        checkOutput("dis_no_strobe", 32'(s_cyc.size() - base_n), 32'd0);
        checkOutput("dis_level_hold", 32'(ev_rx_level), 32'b0010);
        applyStimulus(4'b0000, '0, 1'b0, 1'b0, 8'h00);
        idle(2);

        // Asynchronous reset while a strobe is high and another event is queued
        base_n = s_cyc.size();
        applyStimulus(4'b0101, '0, 1'b0, 1'b0, 8'h00);
        applyStimulus(4'b0000, '0, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #2;
        checkOutput("rst_pre_strobe", 32'(uart.wr_uart), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_wr_uart", 32'(uart.wr_uart), 32'd0);
        checkOutput("rst_w_data", 32'(uart.w_data), 32'd0);
        checkOutput("rst_outputs", 32'({ev_rx_pulse, ev_rx_level, drop_cnt, unk_cnt}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        idle(40);
        checkOutput("rst_no_resend", 32'(s_cyc.size() - base_n), 32'd0);

        // Randomized traffic on both paths
        for (int c = 0; c < 3000; c++) begin
            ev  = ev_in;
            clr = '0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) ev[i] = ~ev[i];
                if ($urandom_range(0, 15) == 0) clr[i] = 1'b1;
            end
            rd = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(8'h3F, 8'h46));
            applyStimulus(ev, clr, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, rd);
            if ($urandom_range(0, 99) == 0) link_en = ~link_en;
        end
        link_en = 1'b1;
        applyStimulus('0, '0, 1'b0, 1'b0, 8'h00);
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
